// File: rtl/neuron_lut_loader.sv
// neuron_lut_loader: beat-wise loader for a neuron lookup table with a one-cycle registered lookup port
module neuron_lut_loader #(
  parameter int IN_BITS      = 6,
  parameter int OUT_BITS     = 2,
  parameter int BEAT_ENTRIES = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_start,
  input  logic                             cfg_valid,
  input  logic [BEAT_ENTRIES*OUT_BITS-1:0] cfg_data,
  output logic                             cfg_ready,
  input  logic [IN_BITS-1:0]               lut_in,
  input  logic                             lut_in_valid,
  output logic [OUT_BITS-1:0]              lut_out,
  output logic                             lut_out_valid,
  output logic                             loaded,
  output logic                             busy
);
  localparam int DEPTH = 2 ** IN_BITS;
  localparam logic [IN_BITS-1:0] LAST = IN_BITS'(DEPTH - BEAT_ENTRIES);
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
  state_t state;
  logic [IN_BITS-1:0] addr;
  logic [OUT_BITS-1:0] mem [DEPTH];
  logic accept;
  assign busy = state == LOAD;
  assign cfg_ready = busy;
  assign accept = busy && cfg_valid && !cfg_start;
  // table has no reset; contents only matter once loaded is set
  always_ff @(posedge clk)
    if (accept)
      for (int k = 0; k < BEAT_ENTRIES; k++)
        mem[addr + IN_BITS'(k)] <= cfg_data[k*OUT_BITS +: OUT_BITS];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      loaded        <= 1'b0;
      lut_out       <= '0;
      lut_out_valid <= 1'b0;
    end else begin
      lut_out_valid <= 1'b0;
      if (cfg_start) begin
        state  <= LOAD;
        addr   <= '0;
        loaded <= 1'b0;
      end else if (accept) begin
        addr <= addr == LAST ? '0 : addr + IN_BITS'(BEAT_ENTRIES);
        if (addr == LAST) begin
          state  <= ACTIVE;
          loaded <= 1'b1;
        end
      end
      if (state == ACTIVE && lut_in_valid && !cfg_start) begin
        lut_out       <= mem[lut_in];
        lut_out_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_neuron_lut_loader.sv
// tb_neuron_lut_loader: scoreboard bench for the table loader and its lookup port
module tb_neuron_lut_loader;
  logic clk = 0, rst_n = 0, cfg_start = 0, cfg_valid = 0, lut_in_valid = 0;
  logic [7:0] cfg_data = 0;
  logic [5:0] lut_in = 0;
  logic cfg_ready, lut_out_valid, loaded, busy;
  logic [1:0] lut_out, exp_out;
  logic [1:0] model [64];
  logic [1:0] sb [$];
  int m_state = 0, m_addr = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  neuron_lut_loader dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .lut_in(lut_in),
    .lut_in_valid(lut_in_valid), .lut_out(lut_out), .lut_out_valid(lut_out_valid),
    .loaded(loaded), .busy(busy)
  );

  // results are popped half a cycle after the edge that produced them
  always @(negedge clk) begin
    if (lut_out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid lut_out=%b with no lookup pending", lut_out);
      end else begin
        exp_out = sb.pop_front();
        if (lut_out !== exp_out) begin
          errors++;
          $display("FAIL lookup_data got %b expected %b", lut_out, exp_out);
        end
      end
    end else if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_result lut_out_valid=%b expected a result %b", lut_out_valid, sb[0]);
      sb.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_state = 0;
      m_addr = 0;
    end else begin
      if (m_state == 2 && lut_in_valid && !cfg_start) sb.push_back(model[lut_in]);
      if (cfg_start) begin
        m_state = 1;
        m_addr = 0;
      end else if (m_state == 1 && cfg_valid) begin
        for (int k = 0; k < 4; k++) model[m_addr + k] = cfg_data[2*k +: 2];
        m_addr += 4;
        if (m_addr == 64) begin
          m_state = 2;
          m_addr = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    step();
    step();
    checks++;
    if ({busy, cfg_ready, loaded, lut_out_valid, lut_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs busy/ready/loaded/valid/out=%b expected 000000",
               {busy, cfg_ready, loaded, lut_out_valid, lut_out});
    end
    rst_n = 1;
    cfg_valid = 1;
    step();
    cfg_valid = 0;
    checks++;
    if (busy !== 0 || loaded !== 0) begin
      errors++;
      $display("FAIL reset_idle busy=%b loaded=%b expected 0 0", busy, loaded);
    end
  endtask

  task automatic test_full_load();
    cfg_start = 1;
    step();
    cfg_start = 0;
    for (int i = 0; i < 16; i++) begin
      cfg_valid = 1;
      cfg_data = 8'b11_10_01_00;
      checks++;
      if (cfg_ready !== 1) begin
        errors++;
        $display("FAIL full_ready beat %0d cfg_ready=%b expected 1", i, cfg_ready);
      end
      step();
    end
    cfg_valid = 0;
    checks++;
    if (loaded !== 1 || busy !== 0) begin
      errors++;
      $display("FAIL full_done loaded=%b busy=%b expected 1 0", loaded, busy);
    end
    lut_in_valid = 1;
    lut_in = 5;
    step();
    checks++;
    if (lut_out !== 2'b01) begin
      errors++;
      $display("FAIL full_lut5 got %b expected 01", lut_out);
    end
    lut_in = 63;
    step();
    checks++;
    if (lut_out !== 2'b11) begin
      errors++;
      $display("FAIL full_lut63 got %b expected 11", lut_out);
    end
    lut_in_valid = 0;
    step();
  endtask

  task automatic test_reload();
    cfg_start = 1;
    step();
    cfg_start = 0;
    checks++;
    if (loaded !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL reload_start loaded=%b busy=%b expected 0 1", loaded, busy);
    end
    cfg_valid = 1;
    cfg_data = 8'b00_00_00_11;
    for (int i = 0; i < 16; i++) step();
    cfg_valid = 0;
    checks++;
    if (loaded !== 1) begin
      errors++;
      $display("FAIL reload_done loaded=%b expected 1", loaded);
    end
    lut_in_valid = 1;
    lut_in = 4;
    step();
    checks++;
    if (lut_out !== 2'b11) begin
      errors++;
      $display("FAIL reload_lut4 got %b expected 11", lut_out);
    end
    lut_in = 5;
    step();
    checks++;
    if (lut_out !== 2'b00) begin
      errors++;
      $display("FAIL reload_lut5 got %b expected 00", lut_out);
    end
    lut_in_valid = 0;
    step();
  endtask

  task automatic test_backpressure();
    int acc = 0, nv = 0;
    cfg_start = 1;
    step();
    cfg_start = 0;
    for (int i = 0; i < 32; i++) begin
      cfg_valid = (i % 2) == 0;
      cfg_data = 8'($urandom);
      checks++;
      if (loaded !== (acc == 16)) begin
        errors++;
        $display("FAIL bp_loaded cycle %0d loaded=%b after %0d beats", i, loaded, acc);
      end
      if (cfg_valid && cfg_ready) acc++;
      step();
    end
    cfg_valid = 0;
    checks++;
    if (acc != 16 || loaded !== 1) begin
      errors++;
      $display("FAIL bp_count accepted=%0d loaded=%b expected 16 1", acc, loaded);
    end
    lut_in_valid = 1;
    for (int a = 0; a < 64; a++) begin
      lut_in = 6'(a);
      step();
      if (lut_out_valid === 1'b1) nv++;
    end
    lut_in_valid = 0;
    step();
    checks++;
    if (nv != 64) begin
      errors++;
      $display("FAIL bp_back_to_back results=%0d expected 64", nv);
    end
  endtask

  task automatic test_restart();
    lut_in_valid = 1;
    cfg_start = 1;
    step();
    cfg_start = 0;
    cfg_valid = 1;
    for (int i = 0; i < 7; i++) begin
      cfg_data = 8'($urandom);
      lut_in = 6'($urandom);
      step();
    end
    cfg_start = 1;
    cfg_data = 8'hff;
    step();
    cfg_start = 0;
    for (int i = 0; i < 16; i++) begin
      cfg_data = 8'($urandom);
      lut_in = 6'($urandom);
      checks++;
      if (loaded !== 0 || lut_out_valid !== 0) begin
        errors++;
        $display("FAIL restart_gate beat %0d loaded=%b valid=%b expected 0 0", i, loaded, lut_out_valid);
      end
      step();
    end
    cfg_valid = 0;
    lut_in_valid = 0;
    checks++;
    if (loaded !== 1) begin
      errors++;
      $display("FAIL restart_done loaded=%b expected 1", loaded);
    end
    lut_in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      lut_in = 6'($urandom);
      step();
    end
    lut_in_valid = 0;
    step();
  endtask

  task automatic test_gating();
    rst_n = 0;
    step();
    rst_n = 1;
    lut_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      lut_in = 6'($urandom);
      step();
    end
    cfg_start = 1;
    step();
    cfg_start = 0;
    cfg_valid = 1;
    for (int i = 0; i < 16; i++) begin
      cfg_data = 8'($urandom);
      lut_in = 6'($urandom);
      checks++;
      if (lut_out_valid !== 0) begin
        errors++;
        $display("FAIL gate_load beat %0d valid=%b expected 0", i, lut_out_valid);
      end
      step();
    end
    cfg_valid = 0;
    checks++;
    if (lut_out_valid !== 0) begin
      errors++;
      $display("FAIL gate_entry valid=%b expected 0", lut_out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      lut_in = 6'($urandom);
      step();
      checks++;
      if (lut_out_valid !== 1) begin
        errors++;
        $display("FAIL gate_active cycle %0d valid=%b expected 1", i, lut_out_valid);
      end
    end
    lut_in_valid = 0;
    step();
  endtask

  task automatic test_async_reset();
    int a = 0;
    while (a < 63 && model[a] == 2'b00) a++;
    lut_in = 6'(a);
    lut_in_valid = 1;
    step();
    lut_in_valid = 0;
    cfg_start = 1;
    step();
    cfg_start = 0;
    cfg_valid = 1;
    for (int i = 0; i < 10; i++) begin
      cfg_data = 8'($urandom);
      step();
    end
    #2 rst_n = 0;
    m_state = 0;
    m_addr = 0;
    sb.delete();
    #1;
    checks++;
    if ({busy, cfg_ready, loaded, lut_out_valid, lut_out} !== 6'b0) begin
      errors++;
      $display("FAIL async_clear busy/ready/loaded/valid/out=%b expected 000000",
               {busy, cfg_ready, loaded, lut_out_valid, lut_out});
    end
    @(negedge clk);
    rst_n = 1;
    lut_in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      cfg_data = 8'($urandom);
      step();
      checks++;
      if (busy !== 0 || cfg_ready !== 0 || loaded !== 0) begin
        errors++;
        $display("FAIL async_idle cycle %0d busy=%b ready=%b loaded=%b expected 0 0 0", i, busy, cfg_ready, loaded);
      end
    end
    lut_in_valid = 0;
    cfg_valid = 0;
    cfg_start = 1;
    step();
    cfg_start = 0;
    cfg_valid = 1;
    for (int i = 0; i < 16; i++) begin
      cfg_data = 8'($urandom);
      checks++;
      if (loaded !== 0) begin
        errors++;
        $display("FAIL async_reload beat %0d loaded=%b expected 0", i, loaded);
      end
      step();
    end
    cfg_valid = 0;
    checks++;
    if (loaded !== 1) begin
      errors++;
      $display("FAIL async_done loaded=%b expected 1", loaded);
    end
    lut_in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      lut_in = 6'($urandom);
      step();
    end
    lut_in_valid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_reload();
    test_backpressure();
    test_restart();
    test_gating();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_lut_loader.md
NEURON_LUT_LOADER -- requirements
Module: neuron_lut_loader

Interface
REQ-001 Parameter IN_BITS, default 6, lookup address width; table depth is 2**IN_BITS entries.
REQ-002 Parameter OUT_BITS, default 2, width of one table entry.
REQ-003 Parameter BEAT_ENTRIES, default 4, table entries carried per config beat; 2**IN_BITS SHALL be a multiple of BEAT_ENTRIES.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port list, in order:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_start  input  1  one-cycle pulse that begins a table load.
- cfg_valid  input  1  config beat valid.
- cfg_data  input  BEAT_ENTRIES*OUT_BITS  packed entries; entry k = bits [k*OUT_BITS +: OUT_BITS].
- cfg_ready  output  1  block accepts a beat this cycle.
- lut_in  input  IN_BITS  lookup address (neuron input word).
- lut_in_valid  input  1  lookup request.
- lut_out  output  OUT_BITS  registered table entry.
- lut_out_valid  output  1  lut_out holds a lookup result.
- loaded  output  1  complete table present.
- busy  output  1  load in progress.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, LOAD and ACTIVE.
REQ-007 In IDLE or ACTIVE, cfg_start=1 SHALL cause three effects on the next edge: enter LOAD, clear the write address to 0, and clear loaded.
REQ-008 In LOAD, cfg_start=1 SHALL restart the load: the write address returns to 0, and any beat presented in the same cycle is discarded.
REQ-009 cfg_ready SHALL be 1 only in LOAD; busy SHALL equal (state==LOAD).
REQ-010 A beat is accepted when cfg_valid and cfg_ready are both 1 and cfg_start is 0.
- Entry k is written to table[addr+k] for k = 0..BEAT_ENTRIES-1.
- addr then advances by BEAT_ENTRIES.
REQ-011 Acceptance of the beat that writes the last entry (addr = 2**IN_BITS - BEAT_ENTRIES) SHALL have three effects on the next edge: enter ACTIVE, set loaded=1, and wrap addr to 0.
REQ-012 cfg_valid in IDLE or ACTIVE SHALL be ignored and SHALL NOT alter the table.
REQ-013 A lookup SHALL have one-cycle latency, per cycle N:
- In ACTIVE with lut_in_valid=1 in cycle N: in cycle N+1, lut_out = table[lut_in sampled in N] and lut_out_valid=1.
- Otherwise: in cycle N+1, lut_out_valid=0 and lut_out holds its previous value.
REQ-014 Lookups SHALL be suppressed outside ACTIVE, including in the cycle cfg_start is sampled: lut_out_valid=0 on the following edge.
REQ-015 A beat write and a lookup SHALL never coincide, because lookups are suppressed during LOAD; no read-during-write bypass is required.
REQ-016 Back-to-back lookups every cycle in ACTIVE SHALL produce one result per cycle with no bubbles.
REQ-017 Table storage SHALL be a distributed-style register array with no reset; its contents are not observable until loaded=1.

Reset
REQ-018 Assertion of rst_n=0 SHALL act asynchronously and force all of the following: state=IDLE, addr=0, loaded=0, busy=0, cfg_ready=0, lut_out=0, lut_out_valid=0.
REQ-019 Reset asserted during LOAD SHALL abandon the partial load; after deassertion, loaded stays 0 until a complete new load finishes.
REQ-020 The first edge after rst_n deassertion SHALL evaluate inputs normally; no extra synchronisation cycles are required.

Verification
REQ-021 Full load with defaults: cfg_start, then 16 beats with cfg_data=8'b11_10_01_00 and cfg_valid held high.
- Expected: cfg_ready=1 for all 16 cycles, then loaded=1 and busy=0.
- Then lut_in=5 gives lut_out=2'b01 one cycle later; lut_in=63 gives 2'b11.
REQ-022 Backpressure gaps: load with cfg_valid toggling 1/0.
- Expected: exactly 16 accepted beats, loaded=1 only after the 16th.
- Readback of all 64 addresses matches the written pattern.
REQ-023 Restart mid-load: after 7 beats, pulse cfg_start with cfg_valid=1.
- Expected: that beat is discarded and addr=0.
- A further 16 beats are needed before loaded=1; lookups stay suppressed throughout.
REQ-024 Lookup gating: lut_in_valid=1 continuously from reset through a load.
- Expected: lut_out_valid=0 in IDLE and LOAD.
- Expected: lut_out_valid=1 starting the cycle after ACTIVE is entered, every cycle, with correct data.
REQ-025 Async reset mid-load: drive rst_n low between edges after 10 beats.
- Expected: outputs clear immediately, before the next edge, to the REQ-018 values.
- Expected: after release, state=IDLE and cfg_valid is ignored until cfg_start.
REQ-026 Reload in ACTIVE: from ACTIVE, load a new pattern 8'b00_00_00_11.
- Expected: loaded drops the cycle after cfg_start.
- After reload, lut_in=4 gives 2'b11 and lut_in=5 gives 2'b00.
